// File: rtl/shift_reg_ctrl.sv
// Sequencer for a WIDTH-bit serial-in shift register: takes a word over valid/ready,
// shifts it out MSB-first, reads the register back and tracks match/mismatch.
module shift_reg_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] Q_IN,
  output logic             SER,
  output logic             SHIFT_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             MATCH,
  output logic [7:0]       ERR_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  // One counter serves both the bit index in SHIFT and the idle count in GAP.
  localparam int CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             shift_en_q, shift_en_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Bit that goes out on the next shift edge: shadow[WIDTH-1-(cnt+1)].
  logic [WIDTH-1:0] shadow_shl;
  assign shadow_shl = shadow_q << (cnt_q + CNT_ONE);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    ser_d      = ser_q;
    shift_en_d = shift_en_q;
    done_d     = 1'b0;
    match_d    = match_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (DIN_VALID) begin
          shadow_d   = DIN;
          cnt_d      = '0;
          shift_en_d = 1'b1;
          ser_d      = DIN[WIDTH-1];
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (ABORT) begin
          shift_en_d = 1'b0;
          ser_d      = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q == LAST_BIT) begin
          shift_en_d = 1'b0;
          ser_d      = 1'b0;
          state_d    = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          ser_d = shadow_shl[WIDTH-1];
        end
      end

      CHECK: begin
        if (ABORT) begin
          shift_en_d = 1'b0;
          ser_d      = 1'b0;
          state_d    = IDLE;
        end else begin
          done_d  = 1'b1;
          match_d = (Q_IN == shadow_q);
          if ((Q_IN != shadow_q) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end

      GAP: begin
        if (cnt_q == LAST_GAP) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      cnt_q      <= '0;
      ser_q      <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      ser_q      <= ser_d;
      shift_en_q <= shift_en_d;
      done_q     <= done_d;
      match_q    <= match_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Ready only once reset is released, so nothing is offered while held in reset.
  assign DIN_READY = (state_q == IDLE) && !RST;
  assign BUSY      = (state_q != IDLE);
  assign SER       = ser_q;
  assign SHIFT_EN  = shift_en_q;
  assign DONE      = done_q;
  assign MATCH     = match_q;
  assign ERR_CNT   = err_cnt_q;

`ifndef SYNTHESIS
  a_done_pulse: assert property (@(posedge Clk) disable iff (RST) DONE |=> !DONE);
  a_shift_busy: assert property (@(posedge Clk) disable iff (RST) SHIFT_EN |-> BUSY);
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a behavioural loopback shift register,
// plus a second instance built with GAP_CYCLES=0 for back-to-back timing.
module tb_shift_reg_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       RST;
  logic [7:0] din, q_in;
  logic       din_valid, din_ready, abort;
  logic       ser, shift_en, busy, done, match;
  logic [7:0] err_cnt;

  logic [7:0] din0, q_in0;
  logic       din_valid0, din_ready0, abort0;
  logic       ser0, shift_en0, busy0, done0, match0;
  logic [7:0] err_cnt0;

  shift_reg_ctrl #(.WIDTH(8), .GAP_CYCLES(2)) u_dut (
    .Clk(Clk), .RST(RST), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .ABORT(abort), .Q_IN(q_in), .SER(ser), .SHIFT_EN(shift_en), .BUSY(busy),
    .DONE(done), .MATCH(match), .ERR_CNT(err_cnt)
  );

  shift_reg_ctrl #(.WIDTH(8), .GAP_CYCLES(0)) u_dut0 (
    .Clk(Clk), .RST(RST), .DIN(din0), .DIN_VALID(din_valid0), .DIN_READY(din_ready0),
    .ABORT(abort0), .Q_IN(q_in0), .SER(ser0), .SHIFT_EN(shift_en0), .BUSY(busy0),
    .DONE(done0), .MATCH(match0), .ERR_CNT(err_cnt0)
  );

  // External shift registers closing the loop; lb_zero models a stuck-at-0 readback.
  logic [7:0] lb_q  = 8'h00;
  logic [7:0] lb0_q = 8'h00;
  logic       lb_zero = 1'b0;
  always @(posedge Clk) if (shift_en)  lb_q  <= {lb_q[6:0], ser};
  always @(posedge Clk) if (shift_en0) lb0_q <= {lb0_q[6:0], ser0};
  assign q_in  = lb_zero ? 8'h00 : lb_q;
  assign q_in0 = lb0_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Full word from IDLE, checking SER stream, SHIFT_EN length, DONE timing and gap.
  task automatic xfer(input string tag, input logic [7:0] w, input logic exp_match,
                      input logic [7:0] exp_err);
    logic [7:0] sv;
    int en_cnt;
    chk({tag, "_rdy0"}, din_ready, 1'b1);
    din = w; din_valid = 1'b1;
    tick;                               // E0
    din_valid = 1'b0; din = ~w;         // mid-word DIN change must not matter
    sv = 8'h00; en_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      en_cnt += int'(shift_en);
      sv = {sv[6:0], ser};
      tick;
    end                                 // now after E8
    chk({tag, "_en_cnt"}, en_cnt, 8);
    chk({tag, "_ser"}, sv, w);
    chk({tag, "_en_e8"}, shift_en, 1'b0);
    chk({tag, "_busy_e8"}, busy, 1'b1);
    chk({tag, "_done_e8"}, done, 1'b0);
    tick;                               // E9
    chk({tag, "_done_e9"}, done, 1'b1);
    chk({tag, "_match"}, match, exp_match);
    chk({tag, "_err"}, err_cnt, exp_err);
    tick;                               // E10
    chk({tag, "_done_e10"}, done, 1'b0);
    chk({tag, "_rdy_e10"}, din_ready, 1'b0);
    tick;                               // E11
    chk({tag, "_rdy_e11"}, din_ready, 1'b1);
    chk({tag, "_busy_e11"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones, low, dcnt, nrdy, prev_t;
    RST = 1'b1; din = 8'h00; din_valid = 1'b0; abort = 1'b0;
    din0 = 8'h55; din_valid0 = 1'b0; abort0 = 1'b0;
    #12;
    chk("rst_ser", ser, 1'b0);
    chk("rst_en", shift_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_match", match, 1'b0);
    chk("rst_err", err_cnt, 8'd0);
    chk("rst_rdy", din_ready, 1'b0);
    @(negedge Clk); RST = 1'b0; #1;
    chk("post_rst_rdy", din_ready, 1'b1);

    // Basic word with correct loopback
    xfer("a5", 8'hA5, 1'b1, 8'd0);

    // Stuck readback, then saturate the error counter
    lb_zero = 1'b1;
    xfer("ff", 8'hFF, 1'b0, 8'd1);
    din = 8'hFF; din_valid = 1'b1; dones = 0;
    for (int c = 0; c < 300 * 12 + 50 && dones < 299; c++) begin
      tick;
      if (done) begin
        dones++;
        if (dones == 253) chk("err_254", err_cnt, 8'd254);
        if (dones == 254) chk("err_255", err_cnt, 8'd255);
      end
    end
    din_valid = 1'b0;
    chk("sat_dones", dones, 299);
    chk("sat_err", err_cnt, 8'd255);
    chk("sat_match", match, 1'b0);
    tick; tick;
    lb_zero = 1'b0;
    chk("sat_idle", din_ready, 1'b1);

    // DIN_VALID held high: 3C then C3, 12 edges apart
    din = 8'h3C; din_valid = 1'b1;
    tick;                               // first accept
    din = 8'hC3;
    low = 0; dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (din_ready) break;
      low++;
      if (done) begin dcnt++; chk("b2b_match1", match, 1'b1); end
      tick;
    end
    chk("b2b_low", low, 11);
    tick;                               // 12th edge: second accept
    din_valid = 1'b0;
    chk("b2b_busy2", busy, 1'b1);
    chk("b2b_en2", shift_en, 1'b1);
    chk("b2b_ser2", ser, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (din_ready) break;
      if (done) begin dcnt++; chk("b2b_match2", match, 1'b1); end
      tick;
    end
    chk("b2b_dones", dcnt, 2);
    chk("b2b_err", err_cnt, 8'd255);

    // ABORT at 4th SHIFT cycle
    din = 8'h5A; din_valid = 1'b1;
    tick; din_valid = 1'b0;
    tick; tick; tick;
    chk("ab_en_pre", shift_en, 1'b1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_en", shift_en, 1'b0);
    chk("ab_ser", ser, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_rdy", din_ready, 1'b1);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      tick;
    end
    chk("ab_no_done", dones, 0);
    chk("ab_match", match, 1'b1);
    chk("ab_err", err_cnt, 8'd255);

    // ABORT together with DIN_VALID in IDLE: accepted, then aborted in SHIFT
    abort = 1'b1; din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    chk("abv_busy", busy, 1'b1);
    tick;
    abort = 1'b0;
    chk("abv_busy2", busy, 1'b0);
    chk("abv_en2", shift_en, 1'b0);

    // Asynchronous reset mid-SHIFT
    din = 8'h7E; din_valid = 1'b1;
    tick; din_valid = 1'b0;
    tick; tick; tick;
    chk("ar_ser_pre", ser, 1'b1);
    chk("ar_en_pre", shift_en, 1'b1);
    #2; RST = 1'b1; #1;
    chk("ar_en", shift_en, 1'b0);
    chk("ar_ser", ser, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_err", err_cnt, 8'd0);
    chk("ar_match", match, 1'b0);
    @(negedge Clk); RST = 1'b0; #1;
    xfer("r81", 8'h81, 1'b1, 8'd0);

    // GAP_CYCLES=0 instance: accept every 10 edges, DONE coincides with DIN_READY
    chk("g0_rdy0", din_ready0, 1'b1);
    din_valid0 = 1'b1;
    nrdy = 0; prev_t = 0;
    for (int t = 1; t <= 31; t++) begin
      tick;
      chk("g0_done_rdy", done0, din_ready0);
      if (din_ready0) begin
        nrdy++;
        chk("g0_match", match0, 1'b1);
        chk("g0_period", t - prev_t, 10);
        prev_t = t;
      end
    end
    din_valid0 = 1'b0;
    chk("g0_nrdy", nrdy, 3);
    chk("g0_err", err_cnt0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
